// File: rtl/skewed_input_feeder.sv
// Per-lane activation FIFOs that stream bursts into a systolic array, lane i delayed i cycles.
// Optional SKEWED_INPUT_FEEDER_ZERO_FILL_EN: lanes drive zero data whenever their valid is low.
module skewed_input_feeder #(
    parameter int ROWS  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_valid,
    input  logic [ROWS-1:0][WIDTH-1:0] i_wr_data,
    output logic                       o_wr_ready,
    input  logic                       i_start,
    input  logic [LEN_W-1:0]           i_len,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [ROWS-1:0]            o_valid,
    output logic [ROWS-1:0][WIDTH-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mem [ROWS][DEPTH];
    logic [AW-1:0]    r_wr_ptr [ROWS];
    logic [AW-1:0]    r_rd_ptr [ROWS];
    logic [CW-1:0]    r_count [ROWS];
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued;
    logic [ROWS-1:0]  r_tok;
    logic [ROWS-1:0]  w_tok;
    logic [ROWS-1:0]  w_tok_nxt;
    logic             w_push;
    logic             w_start;
    logic             w_issue;
    logic             w_last;

    // The last lane pops latest, so it is always the fullest lane.
    assign o_wr_ready = (r_count[ROWS-1] < CW'(DEPTH));
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_start    = (r_state == S_IDLE) && i_start;
    assign w_issue    = (r_state == S_STREAM) && (r_count[0] != '0) && (r_issued < r_len);
    assign w_last     = w_issue && (r_issued == r_len - 1'b1);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);

    always_comb begin
        w_tok    = r_tok;
        w_tok[0] = w_issue;
    end

    assign w_tok_nxt = w_tok << 1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = (i_len != '0) ? S_STREAM : S_DONE;
            end
            S_STREAM: begin
                if (w_last) w_state_nxt = (w_tok_nxt == '0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_tok_nxt == '0) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tok    <= '0;
            r_len    <= '0;
            r_issued <= '0;
            o_valid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tok   <= w_tok_nxt;
            o_valid <= w_tok;
            if (w_start) begin
                r_len    <= i_len;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            if (rst) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end else begin
                if (w_push)   r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_tok[i]) r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                case ({w_push, w_tok[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            if (w_push) r_mem[i][r_wr_ptr[i]] <= i_wr_data[i];
        end
    end

    // A token only reaches a lane after the whole vector was written, so the read entry is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            if (rst) begin
                o_data[i] <= '0;
            end else if (w_tok[i]) begin
                o_data[i] <= r_mem[i][r_rd_ptr[i]];
            end
`ifdef SKEWED_INPUT_FEEDER_ZERO_FILL_EN
            else begin
                o_data[i] <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_skewed_input_feeder.sv
// Bench for skewed_input_feeder: directed and random steps checked against a queue/timeline reference model.
module tb_skewed_input_feeder;
    localparam int ROWS  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int LEN_W = 16;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       i_wr_valid = 1'b0;
    logic [ROWS-1:0][WIDTH-1:0] i_wr_data = '0;
    logic                       o_wr_ready;
    logic                       i_start = 1'b0;
    logic [LEN_W-1:0]           i_len = '0;
    logic                       o_busy;
    logic                       o_done;
    logic [ROWS-1:0]            o_valid;
    logic [ROWS-1:0][WIDTH-1:0] o_data;

    skewed_input_feeder #(.ROWS(ROWS), .WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .i_start(i_start), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done),
        .o_valid(o_valid), .o_data(o_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: per-lane queues plus a timeline of issue cycles and burst end cycle.
    int                         cyc = 0;
    bit                         started = 1'b0;
    int                         start_cyc = 0;
    int                         done_cyc = -1;
    int                         m_len = 0;
    int                         m_issued = 0;
    bit                         iss_at [int];
    logic [WIDTH-1:0]           mq [ROWS][$];
    logic [ROWS-1:0]            exp_valid = '0;
    logic [ROWS-1:0][WIDTH-1:0] exp_data = '0;
    int                         last_done_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_idle(input int c);
        return !(started && (c > start_cyc) && ((done_cyc < 0) || (c <= done_cyc)));
    endfunction

    task automatic rand_vec();
        for (int i = 0; i < ROWS; i++) i_wr_data[i] = WIDTH'($urandom);
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROWS; i++) mq[i].delete();
        iss_at.delete();
        started   = 1'b0;
        done_cyc  = -1;
        m_len     = 0;
        m_issued  = 0;
        exp_valid = '0;
        exp_data  = '0;
    endtask

    task automatic tick();
        bit idle;
        bit rdy;
        bit iss;
        idle = model_idle(cyc);
        rdy  = (mq[ROWS-1].size() < DEPTH);
        chk("wr_ready", 64'(o_wr_ready), 64'(rdy));
        iss = !idle && (m_issued < m_len) && (mq[0].size() != 0);
        if (iss) begin
            iss_at[cyc] = 1'b1;
            m_issued++;
            if (m_issued == m_len) done_cyc = cyc + ROWS;
        end
        for (int i = 0; i < ROWS; i++) begin
            if (iss_at.exists(cyc - i)) begin
                exp_valid[i] = 1'b1;
                exp_data[i]  = mq[i].pop_front();
            end else begin
                exp_valid[i] = 1'b0;
`ifdef SKEWED_INPUT_FEEDER_ZERO_FILL_EN
                exp_data[i]  = '0;
`endif
            end
        end
        if (i_wr_valid && rdy) begin
            for (int i = 0; i < ROWS; i++) mq[i].push_back(i_wr_data[i]);
        end
        if (idle && i_start) begin
            started   = 1'b1;
            start_cyc = cyc;
            m_len     = int'(i_len);
            m_issued  = 0;
            done_cyc  = (i_len == '0) ? cyc + 1 : -1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (o_done) last_done_cyc = cyc;
        chk("valid", 64'(o_valid), 64'(exp_valid));
        chk("data",  64'(o_data),  64'(exp_data));
        chk("busy",  64'(o_busy),  64'(!model_idle(cyc)));
        chk("done",  64'(o_done),  64'(cyc == done_cyc));
    endtask

    task automatic do_reset();
        i_wr_valid = 1'b0;
        i_start    = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        model_clear();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data",  64'(o_data),  64'd0);
        chk("rst_done",  64'(o_done),  64'd0);
        chk("rst_busy",  64'(o_busy),  64'd0);
        chk("rst_ready", 64'(o_wr_ready), 64'd1);
    endtask

    task automatic write_vec(input logic [ROWS-1:0][WIDTH-1:0] v);
        i_wr_valid = 1'b1;
        i_wr_data  = v;
        tick();
        i_wr_valid = 1'b0;
    endtask

    task automatic start_burst(input int len);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input bit feed);
        int n;
        n = 0;
        i_start = 1'b0;
        while ((o_busy || !model_idle(cyc)) && (n < 300)) begin
            i_wr_valid = feed;
            if (feed) rand_vec();
            tick();
            n++;
        end
        i_wr_valid = 1'b0;
        chk("idle_reached", 64'(o_busy), 64'd0);
    endtask

    initial begin
        int t0;
        logic [ROWS-1:0][WIDTH-1:0] v;

        do_reset();

        // Two known vectors, burst of 2.
        for (int i = 0; i < ROWS; i++) v[i] = WIDTH'(i + 1);
        write_vec(v);
        for (int i = 0; i < ROWS; i++) v[i] = WIDTH'(i + 5);
        write_vec(v);
        t0 = cyc;
        start_burst(2);
        wait_idle(1'b0);
        chk("t1_done_latency", 64'(last_done_cyc - t0), 64'(2 + ROWS));

        // Zero-length burst.
        t0 = cyc;
        start_burst(0);
        tick();
        chk("len0_done_latency", 64'(last_done_cyc - t0), 64'd1);

        // Start on empty FIFOs, trickle writes, stray start while streaming.
        start_burst(3);
        tick();
        i_start = 1'b1;
        i_len   = LEN_W'(7);
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_wr_valid = 1'b1;
            rand_vec();
            tick();
            i_wr_valid = 1'b0;
            tick();
        end
        wait_idle(1'b0);

        // Fill to DEPTH, extra write dropped, then drain.
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < ROWS; i++) v[i] = WIDTH'(k * 16 + i);
            write_vec(v);
        end
        chk("full_ready", 64'(o_wr_ready), 64'd0);
        for (int i = 0; i < ROWS; i++) v[i] = 8'hEE;
        write_vec(v);
        start_burst(DEPTH);
        wait_idle(1'b0);

        // Long burst with a write every cycle.
        i_wr_valid = 1'b1;
        rand_vec();
        start_burst(2 * DEPTH);
        i_wr_valid = 1'b1;
        for (int k = 1; k < 2 * DEPTH; k++) begin
            rand_vec();
            tick();
        end
        i_wr_valid = 1'b0;
        wait_idle(1'b0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            i_wr_valid = ($urandom_range(0, 2) != 0);
            rand_vec();
            i_start = ($urandom_range(0, 15) == 0);
            i_len   = LEN_W'($urandom_range(0, 12));
            tick();
        end
        wait_idle(1'b1);

        // Reset in the middle of a burst, then a fresh burst.
        for (int k = 0; k < 5; k++) begin
            rand_vec();
            write_vec(i_wr_data);
        end
        start_burst(5);
        tick();
        tick();
        tick();
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            rand_vec();
            write_vec(i_wr_data);
        end
        t0 = cyc;
        start_burst(3);
        wait_idle(1'b0);
        chk("post_rst_done_latency", 64'(last_done_cyc - t0), 64'(3 + ROWS));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
